vme_wide_reg_bank: RTL and testbench

VME_WIDE_REG_BANK -- requirements
Module: vme_wide_reg_bank

---
 rtl/vme_reg_pkg.sv | 49 ++++
 rtl/vme_wide_reg_chan.sv | 74 +++++++
 rtl/vme_wide_reg_bank.sv | 105 ++++++++++
 tb/tb_vme_wide_reg_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vme_reg_pkg.sv
// Shared constants and address decode for the VME wide register bank.
// Provides word/address widths, channel stride, control base and decode type.
package vme_reg_pkg;

  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 19;
  localparam int CHAN_STRIDE = 4;
  localparam int CTRL_BASE   = 256;
  localparam int MAX_CHANS   = 64;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_STS,
    SP_CTRL
  } space_e;

  typedef struct packed {
    space_e     space;
    logic [5:0] channel;
    logic [1:0] word;
    logic       valid;
  } addr_dec_t;

  function automatic addr_dec_t addr_decode(
    input logic [ADDR_W-1:0] a,
    input int                nregs,
    input int                nwords
  );
    addr_dec_t d;
    int        off;
    d.space = SP_NONE;
    off     = 0;
    if (int'(a) < CTRL_BASE) begin
      d.space = SP_STS;
      off     = int'(a);
    end else if (int'(a) < CTRL_BASE + MAX_CHANS * CHAN_STRIDE) begin
      d.space = SP_CTRL;
      off     = int'(a) - CTRL_BASE;
    end
    d.channel = 6'(off / CHAN_STRIDE);
    d.word    = 2'(off % CHAN_STRIDE);
    // Out-of-range channels and words beyond the channel width are unmapped.
    d.valid   = (d.space != SP_NONE) &&
                (off / CHAN_STRIDE < nregs) &&
                (off % CHAN_STRIDE < nwords);
    return d;
  endfunction

endpackage

// File: rtl/vme_wide_reg_chan.sv
// One wide channel: status shadow (SNAPSHOT_EN), control staging, commit reg.
// Ports: i_sts in, i_cap/i_wr_* strobes, o_sts_view, o_ctrl, o_ctrl_wr out.
module vme_wide_reg_chan
  import vme_reg_pkg::*;
#(
  parameter int REG_WORDS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [REG_WORDS*WORD_W-1:0] i_sts,
  input  logic                        i_cap,
  input  logic                        i_wr_en,
  input  logic [1:0]                  i_wr_word,
  input  logic [WORD_W-1:0]           i_wr_data,
  output logic [REG_WORDS*WORD_W-1:0] o_sts_view,
  output logic [REG_WORDS*WORD_W-1:0] o_ctrl,
  output logic                        o_ctrl_wr
);

  localparam int         CW   = REG_WORDS * WORD_W;
  localparam logic [1:0] LAST = 2'(REG_WORDS - 1);

  logic [CW-1:0] r_stage;
  logic [CW-1:0] r_ctrl;
  logic          r_ctrl_wr;
  logic [CW-1:0] w_commit;
  logic          w_last;

  assign w_last = i_wr_en && (i_wr_word == LAST);

  // Last word is the least significant one and lands straight in ctrl.
  always_comb begin
    w_commit               = r_stage;
    w_commit[WORD_W-1:0]   = i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stage   <= '0;
      r_ctrl    <= '0;
      r_ctrl_wr <= 1'b0;
    end else begin
      r_ctrl_wr <= w_last;
      if (w_last) r_ctrl <= w_commit;
      for (int w = 0; w < REG_WORDS - 1; w++) begin
        if (i_wr_en && i_wr_word == 2'(w))
          r_stage[(REG_WORDS-1-w)*WORD_W +: WORD_W] <= i_wr_data;
      end
    end
  end

  assign o_ctrl    = r_ctrl;
  assign o_ctrl_wr = r_ctrl_wr;

`ifdef SNAPSHOT_EN
  logic [CW-1:0] r_shadow;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_shadow <= '0;
    else if (i_cap) r_shadow <= i_sts;
  end

  // Word 0 is always live; the read of it is what takes the snapshot.
  always_comb begin
    o_sts_view                = r_shadow;
    o_sts_view[CW-1 -: WORD_W] = i_sts[CW-1 -: WORD_W];
  end
`else
  logic w_unused_cap;
  assign w_unused_cap = i_cap;
  assign o_sts_view   = i_sts;
`endif

endmodule

// File: rtl/vme_wide_reg_bank.sv
// VME bank of wide status/control channels; SNAPSHOT_EN enables tear-free status.
// Ports: VME bus (Addr/WrData/RdData/RdMem/WrMem/Done), sts_i, ctrl_o, ctrl_wr_o.
module vme_wide_reg_bank
  import vme_reg_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int REG_WORDS = 4
) (
  input  logic                                 Clk,
  input  logic                                 rst_n,
  input  logic [19:1]                          VMEAddr,
  input  logic [15:0]                          VMEWrData,
  output logic [15:0]                          VMERdData,
  input  logic                                 VMERdMem,
  input  logic                                 VMEWrMem,
  output logic                                 VMERdDone,
  output logic                                 VMEWrDone,
  input  logic [NUM_REGS*REG_WORDS*WORD_W-1:0] sts_i,
  output logic [NUM_REGS*REG_WORDS*WORD_W-1:0] ctrl_o,
  output logic [NUM_REGS-1:0]                  ctrl_wr_o
);

  localparam int CW = REG_WORDS * WORD_W;

  addr_dec_t         w_rd_dec;
  addr_dec_t         w_wr_dec;
  logic              r_wr_vld;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_done;
  logic [WORD_W-1:0] w_rd_data;
  logic [NUM_REGS-1:0] w_cap;
  logic [NUM_REGS-1:0] w_wr_en;
  logic [CW-1:0]     w_view [NUM_REGS];
  logic [CW-1:0]     w_ctrl [NUM_REGS];

  assign w_rd_dec = addr_decode(VMEAddr, NUM_REGS, REG_WORDS);
  assign w_wr_dec = addr_decode(r_wr_addr, NUM_REGS, REG_WORDS);

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      for (int w = 0; w < REG_WORDS; w++) begin
        if (w_rd_dec.valid && w_rd_dec.channel == 6'(k) &&
            w_rd_dec.word == 2'(w)) begin
          if (w_rd_dec.space == SP_STS)
            w_rd_data = w_view[k][(REG_WORDS-1-w)*WORD_W +: WORD_W];
          else
            w_rd_data = w_ctrl[k][(REG_WORDS-1-w)*WORD_W +: WORD_W];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_done <= 1'b0;
      r_wr_vld  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_rd_done <= VMERdMem;
      if (VMERdMem) r_rd_data <= w_rd_data;
      r_wr_vld  <= VMEWrMem;
      r_wr_addr <= VMEAddr;
      r_wr_data <= VMEWrData;
    end
  end

  assign VMERdData = r_rd_data;
  assign VMERdDone = r_rd_done;
  assign VMEWrDone = r_wr_vld;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_chan
    assign w_cap[k] = VMERdMem && w_rd_dec.valid &&
                      w_rd_dec.space == SP_STS &&
                      w_rd_dec.word == 2'd0 &&
                      w_rd_dec.channel == 6'(k);
    // Writes act one cycle after the bus strobe, so a same-cycle read
    // always sees the pre-write control value.
    assign w_wr_en[k] = r_wr_vld && w_wr_dec.valid &&
                        w_wr_dec.space == SP_CTRL &&
                        w_wr_dec.channel == 6'(k);

    vme_wide_reg_chan #(
      .REG_WORDS(REG_WORDS)
    ) u_chan (
      .i_clk     (Clk),
      .i_rst_n   (rst_n),
      .i_sts     (sts_i[k*CW +: CW]),
      .i_cap     (w_cap[k]),
      .i_wr_en   (w_wr_en[k]),
      .i_wr_word (w_wr_dec.word),
      .i_wr_data (r_wr_data),
      .o_sts_view(w_view[k]),
      .o_ctrl    (w_ctrl[k]),
      .o_ctrl_wr (ctrl_wr_o[k])
    );

    assign ctrl_o[k*CW +: CW] = w_ctrl[k];
  end

endmodule

// File: tb/tb_vme_wide_reg_bank.sv
// Scoreboard bench for vme_wide_reg_bank (NUM_REGS=4, REG_WORDS=4).
// Honors SNAPSHOT_EN for status-read expectations.
module tb_vme_wide_reg_bank;

  localparam int NR = 4;
  localparam int RW = 4;
  localparam int CW = RW * 16;

  logic             Clk = 1'b0;
  logic             rst_n;
  logic [19:1]      VMEAddr;
  logic [15:0]      VMEWrData;
  logic [15:0]      VMERdData;
  logic             VMERdMem;
  logic             VMEWrMem;
  logic             VMERdDone;
  logic             VMEWrDone;
  logic [NR*CW-1:0] sts_i;
  logic [NR*CW-1:0] ctrl_o;
  logic [NR-1:0]    ctrl_wr_o;

  vme_wide_reg_bank #(
    .NUM_REGS (NR),
    .REG_WORDS(RW)
  ) dut (
    .Clk      (Clk),
    .rst_n    (rst_n),
    .VMEAddr  (VMEAddr),
    .VMEWrData(VMEWrData),
    .VMERdData(VMERdData),
    .VMERdMem (VMERdMem),
    .VMEWrMem (VMEWrMem),
    .VMERdDone(VMERdDone),
    .VMEWrDone(VMEWrDone),
    .sts_i    (sts_i),
    .ctrl_o   (ctrl_o),
    .ctrl_wr_o(ctrl_wr_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] d;
    int          c;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      wr_q[$];
  rd_exp_t e;
  int      wc;
  int      cyc    = 0;
  int      errs   = 0;
  int      checks = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (VMERdDone) begin
      if (rd_q.size() == 0) chk("rd_spurious", 64'(VMERdDone), 0);
      else begin
        e = rd_q.pop_front();
        chk("rd_data", 64'(VMERdData), 64'(e.d));
        chk("rd_lat", 64'(cyc), 64'(e.c + 1));
      end
    end
    if (VMEWrDone) begin
      if (wr_q.size() == 0) chk("wr_spurious", 64'(VMEWrDone), 0);
      else begin
        wc = wr_q.pop_front();
        chk("wr_lat", 64'(cyc), 64'(wc + 1));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [18:0] a, input logic [15:0] d,
                        input logic [15:0] ex);
    VMERdMem  = rd;
    VMEWrMem  = wr;
    VMEAddr   = a;
    VMEWrData = d;
    if (rd) rd_q.push_back('{d: ex, c: cyc});
    if (wr) wr_q.push_back(cyc);
    @(posedge Clk);
    #1;
    VMERdMem = 1'b0;
    VMEWrMem = 1'b0;
  endtask

  function automatic logic [63:0] ch(input int k);
    return ctrl_o[k*CW +: CW];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    VMEAddr   = '0;
    VMEWrData = '0;
    VMERdMem  = 1'b0;
    VMEWrMem  = 1'b0;
    sts_i     = '0;
    tick(3);
    chk("rst_rddone", 64'(VMERdDone), 0);
    chk("rst_wrdone", 64'(VMEWrDone), 0);
    chk("rst_rddata", 64'(VMERdData), 0);
    chk("rst_ctrl_wr", 64'(ctrl_wr_o), 0);
    for (int k = 0; k < NR; k++) chk("rst_ctrl", ch(k), 0);
    rst_n = 1'b1;
    tick(1);

    // Status snapshot
    sts_i = {64'hA0A1_A2A3_A4A5_A6A7, 64'hB0B1_B2B3_B4B5_B6B7,
             64'h1111_2222_3333_4444, 64'hC0C1_C2C3_C4C5_C6C7};
    access(1, 0, 19'h004, 0, 16'h1111);
    sts_i = '1;
`ifdef SNAPSHOT_EN
    access(1, 0, 19'h005, 0, 16'h2222);
    access(1, 0, 19'h006, 0, 16'h3333);
    access(1, 0, 19'h007, 0, 16'h4444);
`else
    access(1, 0, 19'h005, 0, 16'hFFFF);
    access(1, 0, 19'h006, 0, 16'hFFFF);
    access(1, 0, 19'h007, 0, 16'hFFFF);
`endif
    access(1, 0, 19'h000, 0, 16'hFFFF);
    tick(2);

    // Control staging and atomic commit on ch2
    access(0, 1, 19'h108, 16'hAAAA, 0);
    access(0, 1, 19'h109, 16'hBBBB, 0);
    access(0, 1, 19'h10A, 16'hCCCC, 0);
    tick(2);
    chk("stage_hold", ch(2), 0);
    chk("stage_nostrobe", 64'(ctrl_wr_o), 0);
    access(0, 1, 19'h10B, 16'hDDDD, 0);
    chk("commit_n1", ch(2), 0);
    chk("strobe_n1", 64'(ctrl_wr_o), 0);
    tick(1);
    chk("commit_n2", ch(2), 64'hAAAA_BBBB_CCCC_DDDD);
    chk("strobe_n2", 64'(ctrl_wr_o), 64'(4'b0100));
    chk("commit_other", ch(1), 0);
    tick(1);
    chk("strobe_n3", 64'(ctrl_wr_o), 0);

    // Back-to-back reads of committed control
    access(1, 0, 19'h108, 0, 16'hAAAA);
    access(1, 0, 19'h10B, 0, 16'hDDDD);
    access(1, 0, 19'h10C, 0, 16'h0000);
    tick(2);

    // Unmapped accesses
    access(1, 0, 19'h7FFFF, 0, 16'h0000);
    access(1, 0, 19'h014, 0, 16'h0000);
    access(0, 1, 19'h7FFFF, 16'h5555, 0);
    access(0, 1, 19'h113, 16'h5555, 0);
    tick(3);
    chk("unmap_ctrl", ch(2), 64'hAAAA_BBBB_CCCC_DDDD);
    chk("unmap_ch3", ch(3), 0);
    chk("unmap_strobe", 64'(ctrl_wr_o), 0);

    // Reset mid-operation
    access(0, 1, 19'h108, 16'h1111, 0);
    access(0, 1, 19'h109, 16'h2222, 0);
    tick(2);
    access(1, 1, 19'h10A, 16'h3333, 16'hCCCC);
    rst_n = 1'b0;
    tick(1);
    chk("rst_mid_rddone", 64'(VMERdDone), 0);
    chk("rst_mid_wrdone", 64'(VMEWrDone), 0);
    chk("rst_mid_ctrl", ch(2), 0);
    rst_n = 1'b1;
    tick(1);
    access(0, 1, 19'h10B, 16'h1234, 0);
    tick(1);
    chk("post_rst_commit", ch(2), 64'h0000_0000_0000_1234);
    chk("post_rst_strobe", 64'(ctrl_wr_o), 64'(4'b0100));

    // Same-cycle read and write to the same word
    access(1, 1, 19'h10B, 16'h9999, 16'h1234);
    chk("rdwr_n1", ch(2), 64'h0000_0000_0000_1234);
    tick(1);
    chk("rdwr_n2", ch(2), 64'h0000_0000_0000_9999);

    tick(3);
    chk("rd_q_drain", 64'(rd_q.size()), 0);
    chk("wr_q_drain", 64'(wr_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
